fsc_bank_array: RTL and testbench



---
 rtl/fsc_bank_array_if.sv | 20 ++
 rtl/fsc_bank_array.sv | 126 ++++++++++++
 tb/tb_fsc_bank_array.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fsc_bank_array_if.sv
// Bus bundle for the multi-bank FFT scratch memory: per-bank access controls
// going in, read data, valid, page and collision status coming out.
interface fsc_bank_array_if #(
  parameter int NB = 4,
  parameter int DW = 64,
  parameter int AW = 6
);
  logic [NB-1:0]    WE;
  logic [NB-1:0]    RE;
  logic [NB*AW-1:0] ADDR;
  logic [NB*DW-1:0] D;
  logic             SWAP;
  logic [NB*DW-1:0] Q;
  logic [NB-1:0]    QV;
  logic             PAGE;
  logic [NB-1:0]    COLL;

  modport master (output WE, RE, ADDR, D, SWAP, input Q, QV, PAGE, COLL);
  modport slave  (input WE, RE, ADDR, D, SWAP, output Q, QV, PAGE, COLL);
endinterface

// File: rtl/fsc_bank_array.sv
// Parametrised multi-bank scratch memory with optional ping-pong pages,
// 1- or 2-cycle read latency and sticky per-bank write/read collision flags.
module fsc_bank_array #(
  parameter int NB       = 4,
  parameter int DW       = 64,
  parameter int AW       = 6,
  parameter int RD_LAT   = 1,
  parameter int PINGPONG = 1
) (
  input logic              CLK,
  input logic              RST,
  fsc_bank_array_if.slave  bus
);
  localparam int PW    = (PINGPONG != 0) ? AW + 1 : AW;
  localparam int DEPTH = 1 << PW;

  logic             page_q, page_d;
  logic [NB-1:0]    coll_q, coll_d;
  logic [NB-1:0]    s1_v_q, s1_v_d;
  logic [NB-1:0]    qv_q, qv_d;
  logic [DW-1:0]    s1_data_q [NB];
  logic [DW-1:0]    s1_data_d [NB];
  logic [NB*DW-1:0] q_q, q_d;

  logic [NB-1:0]    rd_fire_s;
  logic [NB-1:0]    src_v_s;
  logic [DW-1:0]    src_data_s [NB];
  logic [DW-1:0]    rd_data_s  [NB];

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] addr_s;
    logic [PW-1:0] wr_addr_s;
    logic [PW-1:0] rd_addr_s;

    assign addr_s = bus.ADDR[b*AW +: AW];

    // Writes go to the current page, reads to the opposite one.
    if (PINGPONG != 0) begin : g_pp
      assign wr_addr_s = {page_q, addr_s};
      assign rd_addr_s = {~page_q, addr_s};
    end else begin : g_sp
      assign wr_addr_s = addr_s;
      assign rd_addr_s = addr_s;
    end

    // Storage array: not cleared by reset, write suppressed while RST is high.
    always_ff @(posedge CLK) begin
      if (bus.WE[b] && !RST) begin
        mem_q[wr_addr_s] <= bus.D[b*DW +: DW];
      end
    end

    assign rd_data_s[b] = mem_q[rd_addr_s];
  end

  // Next-state for page, collision flags and the read pipeline.
  always_comb begin
    rd_fire_s = bus.RE & ~bus.WE;
    coll_d    = coll_q | (bus.RE & bus.WE);
    s1_v_d    = rd_fire_s;
    qv_d      = '0;
    q_d       = q_q;
    src_v_s   = '0;
    for (int b = 0; b < NB; b++) begin
      s1_data_d[b]  = rd_data_s[b];
      src_data_s[b] = '0;
    end

    if ((PINGPONG != 0) && bus.SWAP) begin
      page_d = ~page_q;
    end else begin
      page_d = page_q;
    end

    // With RD_LAT=2 the output register is fed from the extra stage.
    if (RD_LAT == 2) begin
      src_v_s = s1_v_q;
      for (int b = 0; b < NB; b++) begin
        src_data_s[b] = s1_data_q[b];
      end
    end else begin
      src_v_s = rd_fire_s;
      for (int b = 0; b < NB; b++) begin
        src_data_s[b] = rd_data_s[b];
      end
    end

    qv_d = src_v_s;
    for (int b = 0; b < NB; b++) begin
      if (src_v_s[b]) begin
        q_d[b*DW +: DW] = src_data_s[b];
      end else begin
        q_d[b*DW +: DW] = q_q[b*DW +: DW];
      end
    end
  end

  // Control and pipeline registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      page_q <= 1'b0;
      coll_q <= '0;
      s1_v_q <= '0;
      qv_q   <= '0;
      q_q    <= '0;
      for (int b = 0; b < NB; b++) begin
        s1_data_q[b] <= '0;
      end
    end else begin
      page_q <= page_d;
      coll_q <= coll_d;
      s1_v_q <= s1_v_d;
      qv_q   <= qv_d;
      q_q    <= q_d;
      for (int b = 0; b < NB; b++) begin
        s1_data_q[b] <= s1_data_d[b];
      end
    end
  end

  assign bus.Q    = q_q;
  assign bus.QV   = qv_q;
  assign bus.PAGE = page_q;
  assign bus.COLL = coll_q;
endmodule

// File: tb/tb_fsc_bank_array.sv
// Scoreboard bench driving three configurations of fsc_bank_array in lockstep:
// (RD_LAT=1, single page), (RD_LAT=2, ping-pong), (RD_LAT=1, ping-pong).
module tb_fsc_bank_array;
  localparam int NB = 4;
  localparam int DW = 64;
  localparam int AW = 6;
  localparam int ND = 3;

  typedef struct {
    int            bank;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic             CLK;
  logic             RST;
  logic [NB-1:0]    we, re;
  logic [NB*AW-1:0] addr;
  logic [NB*DW-1:0] din;
  logic             swap;

  fsc_bank_array_if #(.NB(NB), .DW(DW), .AW(AW)) ifa ();
  fsc_bank_array_if #(.NB(NB), .DW(DW), .AW(AW)) ifb ();
  fsc_bank_array_if #(.NB(NB), .DW(DW), .AW(AW)) ifc ();

  assign ifa.WE = we;  assign ifa.RE = re;  assign ifa.ADDR = addr;
  assign ifa.D  = din; assign ifa.SWAP = swap;
  assign ifb.WE = we;  assign ifb.RE = re;  assign ifb.ADDR = addr;
  assign ifb.D  = din; assign ifb.SWAP = swap;
  assign ifc.WE = we;  assign ifc.RE = re;  assign ifc.ADDR = addr;
  assign ifc.D  = din; assign ifc.SWAP = swap;

  fsc_bank_array #(.NB(NB), .DW(DW), .AW(AW), .RD_LAT(1), .PINGPONG(0))
    dut_a (.CLK(CLK), .RST(RST), .bus(ifa));
  fsc_bank_array #(.NB(NB), .DW(DW), .AW(AW), .RD_LAT(2), .PINGPONG(1))
    dut_b (.CLK(CLK), .RST(RST), .bus(ifb));
  fsc_bank_array #(.NB(NB), .DW(DW), .AW(AW), .RD_LAT(1), .PINGPONG(1))
    dut_c (.CLK(CLK), .RST(RST), .bus(ifc));

  logic [NB*DW-1:0] q_o [ND];
  logic [NB-1:0]    qv_o [ND];
  logic             page_o [ND];
  logic [NB-1:0]    coll_o [ND];

  assign q_o[0] = ifa.Q;  assign qv_o[0] = ifa.QV;  assign page_o[0] = ifa.PAGE;  assign coll_o[0] = ifa.COLL;
  assign q_o[1] = ifb.Q;  assign qv_o[1] = ifb.QV;  assign page_o[1] = ifb.PAGE;  assign coll_o[1] = ifb.COLL;
  assign q_o[2] = ifc.Q;  assign qv_o[2] = ifc.QV;  assign page_o[2] = ifc.PAGE;  assign coll_o[2] = ifc.COLL;

  // Reference model state, one copy per configuration.
  logic [DW-1:0]    mm [ND][NB][2**(AW+1)];
  logic [NB*DW-1:0] q_m [ND];
  logic [NB-1:0]    coll_m [ND];
  logic             page_m [ND];
  exp_t             sb [ND][$];
  int               edge_n;
  int               n_tests;
  int               n_fail;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int lat_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic bit pp_of(input int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic check_eq(input string tag, input logic [NB*DW-1:0] obs,
                          input logic [NB*DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic idle();
    we   = '0;
    re   = '0;
    addr = '0;
    din  = '0;
    swap = 1'b0;
  endtask

  task automatic set_a(input int b, input logic [AW-1:0] a);
    addr[b*AW +: AW] = a;
  endtask

  task automatic set_d(input int b, input logic [DW-1:0] v);
    din[b*DW +: DW] = v;
  endtask

  task automatic compare_all();
    exp_t          e;
    logic [NB-1:0] mask;
    for (int d = 0; d < ND; d++) begin
      mask = '0;
      while (sb[d].size() > 0 && sb[d][0].due <= edge_n) begin
        e = sb[d].pop_front();
        q_m[d][e.bank*DW +: DW] = e.data;
        mask[e.bank] = 1'b1;
      end
      check_eq($sformatf("qv%0d", d), {{(NB*DW-NB){1'b0}}, qv_o[d]}, {{(NB*DW-NB){1'b0}}, mask});
      check_eq($sformatf("q%0d", d), q_o[d], q_m[d]);
      check_eq($sformatf("page%0d", d), {{(NB*DW-1){1'b0}}, page_o[d]}, {{(NB*DW-1){1'b0}}, page_m[d]});
      check_eq($sformatf("coll%0d", d), {{(NB*DW-NB){1'b0}}, coll_o[d]}, {{(NB*DW-NB){1'b0}}, coll_m[d]});
    end
  endtask

  // Apply the currently driven inputs to the model, clock once, then compare.
  task automatic step();
    exp_t         e;
    logic [AW-1:0] a;
    logic [AW:0]   wa, ra;
    edge_n++;
    for (int d = 0; d < ND; d++) begin
      if (RST) begin
        sb[d].delete();
        q_m[d]    = '0;
        coll_m[d] = '0;
        page_m[d] = 1'b0;
      end else begin
        for (int b = 0; b < NB; b++) begin
          a  = addr[b*AW +: AW];
          wa = pp_of(d) ? {page_m[d], a}  : {1'b0, a};
          ra = pp_of(d) ? {~page_m[d], a} : {1'b0, a};
          if (we[b]) begin
            mm[d][b][wa] = din[b*DW +: DW];
            if (re[b]) coll_m[d][b] = 1'b1;
          end else if (re[b]) begin
            e.bank = b;
            e.data = mm[d][b][ra];
            e.due  = edge_n + lat_of(d) - 1;
            sb[d].push_back(e);
          end
        end
        if (swap && pp_of(d)) page_m[d] = ~page_m[d];
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    edge_n  = 0;
    idle();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;

    // Fill both pages of every bank so any later read has defined data.
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 64; a++) begin
        idle();
        we = '1;
        for (int b = 0; b < NB; b++) begin
          set_a(b, a[AW-1:0]);
          set_d(b, {$urandom, $urandom});
        end
        swap = (a == 63);
        step();
      end
    end

    // Basic write then read on bank 2.
    idle(); we = 4'b0100; set_a(2, 6'd5); set_d(2, 64'hA5A5_0000_0000_0001); step();
    idle(); re = 4'b0100; set_a(2, 6'd5); step();
    idle(); step(); step();

    // Ping-pong page exchange.
    idle(); we = '1;
    for (int b = 0; b < NB; b++) begin set_a(b, 6'd3); set_d(b, 64'h11); end
    step();
    idle(); swap = 1'b1; step();
    idle(); re = '1; for (int b = 0; b < NB; b++) set_a(b, 6'd3); step();
    idle(); we = '1;
    for (int b = 0; b < NB; b++) begin set_a(b, 6'd3); set_d(b, 64'h22); end
    step();
    idle(); re = '1; for (int b = 0; b < NB; b++) set_a(b, 6'd3); step();
    idle(); swap = 1'b1; step();
    idle(); re = '1; for (int b = 0; b < NB; b++) set_a(b, 6'd3); step();
    idle(); step(); step();

    // Collision on bank 1, then read the written page back.
    idle(); we = 4'b0010; re = 4'b0010; set_a(1, 6'd7); set_d(1, 64'h33); step();
    idle(); swap = 1'b1; step();
    idle(); re = 4'b0010; set_a(1, 6'd7); step();
    idle(); step(); step();

    // Back-to-back reads on bank 0.
    for (int a = 0; a < 3; a++) begin
      idle(); re = 4'b0001; set_a(0, a[AW-1:0]); step();
    end
    idle(); step(); step(); step();

    // Reset while a read is in flight, with a write that must be dropped.
    idle(); re = 4'b0001; set_a(0, 6'd4); step();
    idle(); RST = 1'b1; we = 4'b1000; set_a(3, 6'd9); set_d(3, {$urandom, $urandom}); step();
    RST = 1'b0;
    idle(); step();
    idle(); re = 4'b1001; set_a(3, 6'd9); set_a(0, 6'd4); step();
    idle(); swap = 1'b1; step();
    idle(); re = 4'b1001; set_a(3, 6'd9); set_a(0, 6'd4); step();
    idle(); step(); step();

    // All banks written and read at distinct addresses in the same cycle.
    idle(); we = '1;
    for (int b = 0; b < NB; b++) begin
      set_a(b, 6'(10 * (b + 1)));
      set_d(b, {$urandom, $urandom});
    end
    step();
    idle(); swap = 1'b1; step();
    idle(); re = '1; for (int b = 0; b < NB; b++) set_a(b, 6'(10 * (b + 1))); step();
    idle(); step(); step();

    // Random traffic with occasional swaps and resets.
    for (int i = 0; i < 400; i++) begin
      we = NB'($urandom);
      re = NB'($urandom);
      for (int b = 0; b < NB; b++) begin
        set_a(b, AW'($urandom));
        set_d(b, {$urandom, $urandom});
      end
      swap = ($urandom_range(0, 3) == 0);
      RST  = ($urandom_range(0, 49) == 0);
      step();
    end
    RST = 1'b0;
    idle(); step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
